// File: rtl/nios_setup_button_pio_if.sv
// Avalon-MM s1 slave bus shared by the board PIO ports.
interface nios_setup_button_pio_if;
  logic [2:0]  address;
  logic        chipselect;
  logic        read_n;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address, chipselect, read_n, write_n, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, read_n, write_n, writedata,
    output readdata
  );
endinterface

// File: rtl/nios_setup_button_pio.sv
// Push-button/switch input PIO: 2-flop sync, per-bit debounce, W1C edge capture, masked level IRQ.
// Read latency 1, no wait states; the bus can never be stalled.
module nios_setup_button_pio #(
  parameter int               WIDTH           = 2,
  parameter int               DEBOUNCE_CYCLES = 50000,
  parameter int               CNT_W           = 16,
  parameter int               EDGE_TYPE       = 2,
  parameter logic [WIDTH-1:0] IN_RESET_VAL    = '1
) (
  input  logic                      clk,
  input  logic                      reset_n,
  nios_setup_button_pio_if.slave    bus,
  input  logic [WIDTH-1:0]          in_port,
  output logic                      irq
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] sync_meta;
  logic [WIDTH-1:0] sync_q;
  logic [WIDTH-1:0] deb_state;
  logic [CNT_W-1:0] cnt [WIDTH];
  logic [WIDTH-1:0] irqmask;
  logic [WIDTH-1:0] edgecap;

  logic             wr_stb;
  logic             rd_stb;
  logic [WIDTH-1:0] toggle;
  logic [WIDTH-1:0] edge_det;
  logic [WIDTH-1:0] w1c;
  logic [31:0]      rd_mux;
  logic             unused_ok;

  assign wr_stb    = bus.chipselect & ~bus.write_n;
  assign rd_stb    = bus.chipselect & ~bus.read_n;
  assign w1c       = (wr_stb && bus.address == 3'd3) ? bus.writedata[WIDTH-1:0] : '0;
  assign unused_ok = &{1'b0, bus.writedata};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_meta <= IN_RESET_VAL;
      sync_q    <= IN_RESET_VAL;
    end else begin
      sync_meta <= in_port;
      sync_q    <= sync_meta;
    end
  end

  // A bit toggles on the DEBOUNCE_CYCLES-th consecutive cycle that sync differs from it.
  always_comb begin
    toggle   = '0;
    edge_det = '0;
    for (int i = 0; i < WIDTH; i++) begin
      toggle[i] = (sync_q[i] != deb_state[i]) && (cnt[i] == CNT_LAST);
      case (EDGE_TYPE)
        0:       edge_det[i] = toggle[i] & ~deb_state[i];
        1:       edge_det[i] = toggle[i] &  deb_state[i];
        default: edge_det[i] = toggle[i];
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      deb_state <= IN_RESET_VAL;
      for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (sync_q[i] == deb_state[i] || toggle[i]) begin
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
      deb_state <= deb_state ^ toggle;
    end
  end

  always_comb begin
    rd_mux = '0;
    case (bus.address)
      3'd0:    rd_mux[WIDTH-1:0] = deb_state;
      3'd2:    rd_mux[WIDTH-1:0] = irqmask;
      3'd3:    rd_mux[WIDTH-1:0] = edgecap;
      default: rd_mux = '0;
    endcase
  end

  // The read mux sees pre-write register values, so a read racing a write returns the old contents.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irqmask      <= '0;
      edgecap      <= '0;
      bus.readdata <= '0;
      irq          <= 1'b0;
    end else begin
      if (wr_stb && bus.address == 3'd2) begin
        irqmask <= bus.writedata[WIDTH-1:0];
      end
      edgecap <= edge_det | (edgecap & ~w1c);
      if (rd_stb) begin
        bus.readdata <= rd_mux;
      end
      irq <= |(edgecap & irqmask);
    end
  end

endmodule

// File: tb/tb_nios_setup_button_pio.sv
// Directed bench: dut_a captures any edge, dut_b captures rising edges only; both share pins and reset.
module tb_nios_setup_button_pio;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  in_port = 2'b11;
  logic [2:0]  addr = '0;
  logic [31:0] wdata = '0;
  logic        rd_n = 1'b1;
  logic        wr_n = 1'b1;
  logic        cs_a = 1'b0;
  logic        cs_b = 1'b0;
  logic        irq_a;
  logic        irq_b;
  int          tests = 0;
  int          fails = 0;

  always #5 clk = ~clk;

  nios_setup_button_pio_if bus_a ();
  nios_setup_button_pio_if bus_b ();

  assign bus_a.address    = addr;
  assign bus_a.chipselect = cs_a;
  assign bus_a.read_n     = rd_n;
  assign bus_a.write_n    = wr_n;
  assign bus_a.writedata  = wdata;
  assign bus_b.address    = addr;
  assign bus_b.chipselect = cs_b;
  assign bus_b.read_n     = rd_n;
  assign bus_b.write_n    = wr_n;
  assign bus_b.writedata  = wdata;

  nios_setup_button_pio #(.WIDTH(2), .DEBOUNCE_CYCLES(4), .CNT_W(16), .EDGE_TYPE(2), .IN_RESET_VAL(2'b11)) dut_a (
    .clk(clk), .reset_n(reset_n), .bus(bus_a), .in_port(in_port), .irq(irq_a)
  );

  nios_setup_button_pio #(.WIDTH(2), .DEBOUNCE_CYCLES(4), .CNT_W(16), .EDGE_TYPE(0), .IN_RESET_VAL(2'b11)) dut_b (
    .clk(clk), .reset_n(reset_n), .bus(bus_b), .in_port(in_port), .irq(irq_b)
  );

  // Bus tasks start and end on a falling edge; one strobe cycle each.
  task automatic bus_read(input int which, input logic [2:0] a, output logic [31:0] d);
    addr = a; cs_a = (which == 0); cs_b = (which == 1); rd_n = 1'b0;
    @(negedge clk);
    d = (which == 0) ? bus_a.readdata : bus_b.readdata;
    cs_a = 1'b0; cs_b = 1'b0; rd_n = 1'b1;
  endtask

  task automatic bus_write(input int which, input logic [2:0] a, input logic [31:0] d);
    addr = a; wdata = d; cs_a = (which == 0); cs_b = (which == 1); wr_n = 1'b0;
    @(negedge clk);
    cs_a = 1'b0; cs_b = 1'b0; wr_n = 1'b1;
  endtask

  task automatic bus_rw(input logic [2:0] a, input logic [31:0] d, output logic [31:0] q);
    addr = a; wdata = d; cs_a = 1'b1; rd_n = 1'b0; wr_n = 1'b0;
    @(negedge clk);
    q = bus_a.readdata;
    cs_a = 1'b0; rd_n = 1'b1; wr_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    repeat (3) @(negedge clk);
    tests++; if (bus_a.readdata !== 32'h0 || irq_a !== 1'b0) begin
      fails++; $display("FAIL reset_outputs readdata=%h irq=%b want 0/0", bus_a.readdata, irq_a);
    end
    reset_n = 1'b1;
    repeat (4) @(negedge clk);
    bus_read(0, 3'd0, d);
    tests++; if (d !== 32'h3) begin fails++; $display("FAIL reset_data got %h want %h", d, 32'h3); end
    bus_read(0, 3'd2, d);
    tests++; if (d !== 32'h0) begin fails++; $display("FAIL reset_irqmask got %h want %h", d, 32'h0); end
    bus_read(0, 3'd3, d);
    tests++; if (d !== 32'h0) begin fails++; $display("FAIL reset_edgecap got %h want %h", d, 32'h0); end
  endtask

  task automatic test_debounce();
    logic [31:0] d;
    in_port = 2'b10;
    repeat (5) @(negedge clk);
    // This read is registered on the same edge the debounced level flips, so it sees the old level.
    bus_read(0, 3'd0, d);
    tests++; if (d !== 32'h3) begin fails++; $display("FAIL deb_before got %h want %h", d, 32'h3); end
    bus_read(0, 3'd0, d);
    tests++; if (d !== 32'h2) begin fails++; $display("FAIL deb_after got %h want %h", d, 32'h2); end
    bus_read(0, 3'd3, d);
    tests++; if (d !== 32'h1) begin fails++; $display("FAIL deb_edgecap got %h want %h", d, 32'h1); end
    bus_read(1, 3'd3, d);
    tests++; if (d !== 32'h0) begin fails++; $display("FAIL rise_only_press got %h want %h", d, 32'h0); end
    in_port = 2'b11;
    repeat (10) @(negedge clk);
    bus_read(1, 3'd3, d);
    tests++; if (d !== 32'h1) begin fails++; $display("FAIL rise_only_release got %h want %h", d, 32'h1); end
    bus_write(0, 3'd3, 32'h3);
    bus_write(1, 3'd3, 32'h3);
  endtask

  task automatic test_glitch();
    logic [31:0] d;
    bus_write(0, 3'd2, 32'h3);
    in_port = 2'b10;
    repeat (3) @(negedge clk);
    in_port = 2'b11;
    repeat (10) @(negedge clk);
    bus_read(0, 3'd0, d);
    tests++; if (d !== 32'h3) begin fails++; $display("FAIL glitch_data got %h want %h", d, 32'h3); end
    bus_read(0, 3'd3, d);
    tests++; if (d !== 32'h0 || irq_a !== 1'b0) begin
      fails++; $display("FAIL glitch_edgecap got %h irq=%b want 0 irq=0", d, irq_a);
    end
  endtask

  task automatic test_irq_mask();
    logic [31:0] d;
    bus_write(0, 3'd2, 32'h1);
    in_port = 2'b01;
    repeat (10) @(negedge clk);
    bus_read(0, 3'd3, d);
    tests++; if (d !== 32'h2 || irq_a !== 1'b0) begin
      fails++; $display("FAIL masked_edge edgecap=%h irq=%b want 2 irq=0", d, irq_a);
    end
    in_port = 2'b00;
    repeat (6) @(negedge clk);
    tests++; if (irq_a !== 1'b0) begin fails++; $display("FAIL irq_early got %b want 0", irq_a); end
    @(negedge clk);
    tests++; if (irq_a !== 1'b1) begin fails++; $display("FAIL irq_set got %b want 1", irq_a); end
    bus_write(0, 3'd3, 32'h1);
    tests++; if (irq_a !== 1'b1) begin fails++; $display("FAIL irq_hold_on_clear got %b want 1", irq_a); end
    @(negedge clk);
    tests++; if (irq_a !== 1'b0) begin fails++; $display("FAIL irq_cleared got %b want 0", irq_a); end
    bus_read(0, 3'd3, d);
    tests++; if (d !== 32'h2) begin fails++; $display("FAIL w1c_other_bit got %h want %h", d, 32'h2); end
  endtask

  task automatic test_edge_vs_clear();
    logic [31:0] d;
    in_port = 2'b01;
    repeat (5) @(negedge clk);
    bus_write(0, 3'd3, 32'h1);
    @(negedge clk);
    tests++; if (irq_a !== 1'b1) begin fails++; $display("FAIL race_irq got %b want 1", irq_a); end
    bus_read(0, 3'd3, d);
    tests++; if (d !== 32'h3 || irq_a !== 1'b1) begin
      fails++; $display("FAIL race_edgecap got %h irq=%b want 3 irq=1", d, irq_a);
    end
    bus_read(1, 3'd3, d);
    tests++; if (d !== 32'h1) begin fails++; $display("FAIL rise_only_bit0 got %h want %h", d, 32'h1); end
    bus_rw(3'd3, 32'h1, d);
    tests++; if (d !== 32'h3) begin fails++; $display("FAIL read_during_clear got %h want %h", d, 32'h3); end
    bus_read(0, 3'd3, d);
    tests++; if (d !== 32'h2 || irq_a !== 1'b0) begin
      fails++; $display("FAIL after_clear got %h irq=%b want 2 irq=0", d, irq_a);
    end
  endtask

  task automatic test_reg_map();
    logic [31:0] d;
    logic [31:0] exp_map [8];
    exp_map = '{32'h1, 32'h0, 32'h3, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    bus_write(0, 3'd3, 32'hFFFF_FFFF);
    bus_write(0, 3'd2, 32'h0);
    bus_write(0, 3'd0, 32'hFFFF_FFFF);
    bus_write(0, 3'd1, 32'hFFFF_FFFF);
    bus_write(0, 3'd5, 32'hFFFF_FFFF);
    bus_write(0, 3'd2, 32'hFFFF_FFFF);
    bus_write(0, 3'd3, 32'hFFFF_FFFF);
    for (int a = 0; a < 8; a++) begin
      bus_read(0, 3'(a), d);
      tests++; if (d !== exp_map[a]) begin
        fails++; $display("FAIL regmap_addr%0d got %h want %h", a, d, exp_map[a]);
      end
    end
    bus_rw(3'd2, 32'h0, d);
    tests++; if (d !== 32'h3) begin fails++; $display("FAIL rw_old_value got %h want %h", d, 32'h3); end
    bus_read(0, 3'd2, d);
    tests++; if (d !== 32'h0) begin fails++; $display("FAIL rw_new_value got %h want %h", d, 32'h0); end
    bus_write(0, 3'd2, 32'h3);
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    in_port = 2'b11;
    repeat (10) @(negedge clk);
    tests++; if (irq_a !== 1'b1) begin fails++; $display("FAIL pre_reset_irq got %b want 1", irq_a); end
    bus_read(0, 3'd0, d);
    tests++; if (d !== 32'h3) begin fails++; $display("FAIL pre_reset_data got %h want %h", d, 32'h3); end
    in_port = 2'b10;
    repeat (3) @(negedge clk);
    reset_n = 1'b0;
    #1;
    tests++; if (bus_a.readdata !== 32'h0 || irq_a !== 1'b0) begin
      fails++; $display("FAIL async_reset readdata=%h irq=%b want 0/0", bus_a.readdata, irq_a);
    end
    in_port = 2'b11;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (10) @(negedge clk);
    bus_read(0, 3'd3, d);
    tests++; if (d !== 32'h0 || irq_a !== 1'b0) begin
      fails++; $display("FAIL post_reset_edgecap got %h irq=%b want 0 irq=0", d, irq_a);
    end
    bus_read(0, 3'd2, d);
    tests++; if (d !== 32'h0) begin fails++; $display("FAIL post_reset_irqmask got %h want %h", d, 32'h0); end
    bus_read(0, 3'd0, d);
    tests++; if (d !== 32'h3) begin fails++; $display("FAIL post_reset_data got %h want %h", d, 32'h3); end
  endtask

  initial begin
    test_reset();
    test_debounce();
    test_glitch();
    test_irq_mask();
    test_edge_vs_clear();
    test_reg_map();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
